// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that grants NREQ requesters bursts of up to BURST words on one FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add per-requester 16-bit transfer counters on stat_cnt.
module fifo_wr_arb #(
  parameter int DWIDTH = 16,
  parameter int NREQ   = 4,
  parameter int BURST  = 4
) (
  input  logic                     wclk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          grant,
  input  logic                     wfull,
  output logic                     wdv,
  output logic [DWIDTH-1:0]        wdata
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]       stat_cnt
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic            xfer;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) owner = IW'(i);
    end
  end

  // Descending scan leaves the nearest valid requester after last_q in pick.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(last_q) + k) % NREQ]) begin
        pick     = IW'((int'(last_q) + k) % NREQ);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWN;
          grant_d = NREQ'(1) << pick;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (xfer) cnt_d = cnt_q + 4'd1;
        // Release after the last word of a full burst, or as soon as the owner stalls with nothing to send.
        if ((xfer && (cnt_q + 4'd1 == 4'(BURST))) || !req_valid[owner]) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    xfer      = (state_q == OWN) && req_valid[owner] && !wfull && !rst;
    wdv       = xfer;
    grant     = grant_q;
    wdata     = (state_q == OWN) ? req_data[owner*DWIDTH +: DWIDTH] : '0;
    req_ready = ((state_q == OWN) && !wfull && !rst) ? grant_q : '0;
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ-1:0][15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (xfer) stat_d[owner] = stat_q[owner] + 16'd1;
  end

  always_ff @(posedge wclk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_cnt = stat_q;
`endif

endmodule
